// File: rtl/fifo_nibble_packer_pkg.sv
// Shared types and constants for the nibble packer: default widths, FSM states and
// the counter-width helper used by the interface and the RTL.
package fifo_nibble_packer_pkg;

    localparam int unsigned NibWDefault = 4;
    localparam int unsigned NibsDefault = 4;

    typedef enum logic {
        StFill,
        StHold
    } state_e;

    // Bits needed to hold a nibble count in 0..nibs inclusive.
    function automatic int unsigned cnt_width(input int unsigned nibs);
        return $clog2(nibs + 1);
    endfunction

endpackage

// File: rtl/fifo_nibble_packer_if.sv
// FIFO read port plus downstream word handshake of the nibble packer.
// master = packer side, slave = FIFO/consumer side.
interface fifo_nibble_packer_if
    import fifo_nibble_packer_pkg::*;
#(
    parameter int unsigned NIB_W = NibWDefault,
    parameter int unsigned NIBS  = NibsDefault
);

    localparam int unsigned CNT_W = cnt_width(NIBS);

    logic                    mem_empty;
    logic [NIB_W-1:0]        fifo_data;
    logic                    r_en;
    logic                    flush;
    logic [NIB_W*NIBS-1:0]   word_out;
    logic [CNT_W-1:0]        word_cnt;
    logic                    word_valid;
    logic                    word_ready;

    modport master (
        input  mem_empty, fifo_data, flush, word_ready,
        output r_en, word_out, word_cnt, word_valid
    );

    modport slave (
        output mem_empty, fifo_data, flush, word_ready,
        input  r_en, word_out, word_cnt, word_valid
    );

endinterface

// File: rtl/fifo_nibble_packer_slot_reg.sv
// Word register built from NIBS nibble slots: one slot written per cycle by index,
// whole word cleared synchronously.
module fifo_nibble_packer_slot_reg #(
    parameter int unsigned NIB_W = 4,
    parameter int unsigned NIBS  = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  we,
    input  logic [CNT_W-1:0]      idx,
    input  logic [NIB_W-1:0]      din,
    output logic [NIB_W*NIBS-1:0] word
);

    logic [NIB_W*NIBS-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clr) begin
            word_q <= '0;
        end else if (we) begin
            for (int unsigned i = 0; i < NIBS; i++) begin
                if (idx == CNT_W'(i)) begin
                    word_q[i*NIB_W +: NIB_W] <= din;
                end
            end
        end
    end

    assign word = word_q;

endmodule

// File: rtl/fifo_nibble_packer.sv
// Read-side consumer of the nibble FIFO: pops entries, packs NIBS of them LSB-first
// into a word and offers it on valid/ready; flush emits a partial word with its count.
module fifo_nibble_packer
    import fifo_nibble_packer_pkg::*;
#(
    parameter int unsigned NIB_W = NibWDefault,
    parameter int unsigned NIBS  = NibsDefault
) (
    input  logic                 rclk,
    input  logic                 rst_n,
    fifo_nibble_packer_if.master bus
);

    localparam int unsigned       CNT_W   = cnt_width(NIBS);
    localparam logic [CNT_W-1:0]  CntFull = CNT_W'(NIBS);
    localparam logic [CNT_W:0]    NibsExt = (CNT_W + 1)'(NIBS);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                inflight_q;
    logic                flush_pend_q;
    logic [CNT_W-1:0]    word_cnt_q;
    logic                word_valid_q;

    logic [CNT_W:0]      occupancy;
    logic [CNT_W-1:0]    cnt_inc;
    logic                r_en;
    logic                capture;
    logic                clear_word;
    logic [NIB_W*NIBS-1:0] word;

    // Slots already filled plus the one whose data arrives next edge.
    assign occupancy  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};
    assign cnt_inc    = cnt_q + CNT_W'(1);

    // Gated with rst_n so no pop request escapes while the FIFO side sees reset.
    assign r_en = rst_n && (state_q == StFill) && !bus.mem_empty && !flush_pend_q &&
                  (occupancy < NibsExt);

    assign capture    = (state_q == StFill) && inflight_q;
    assign clear_word = (state_q == StHold) && bus.word_ready;

    fifo_nibble_packer_slot_reg #(
        .NIB_W (NIB_W),
        .NIBS  (NIBS),
        .CNT_W (CNT_W)
    ) u_slot_reg (
        .clk   (rclk),
        .rst_n (rst_n),
        .clr   (clear_word),
        .we    (capture),
        .idx   (cnt_q),
        .din   (bus.fifo_data),
        .word  (word)
    );

    always_ff @(posedge rclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFill;
            cnt_q        <= '0;
            inflight_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            word_cnt_q   <= '0;
            word_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StFill: begin
                    inflight_q <= r_en;
                    if (inflight_q) begin
                        cnt_q <= cnt_inc;
                    end
                    if (inflight_q && (cnt_inc == CntFull)) begin
                        state_q      <= StHold;
                        word_valid_q <= 1'b1;
                        word_cnt_q   <= CntFull;
                        flush_pend_q <= 1'b0;
                    end else if (flush_pend_q && !inflight_q) begin
                        state_q      <= StHold;
                        word_valid_q <= 1'b1;
                        word_cnt_q   <= cnt_q;
                        flush_pend_q <= 1'b0;
                    end else if (bus.flush && ((cnt_q != '0) || inflight_q)) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                StHold: begin
                    inflight_q <= 1'b0;
                    if (bus.word_ready) begin
                        state_q      <= StFill;
                        word_valid_q <= 1'b0;
                        word_cnt_q   <= '0;
                        cnt_q        <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.r_en       = r_en;
    assign bus.word_out   = word;
    assign bus.word_cnt   = word_cnt_q;
    assign bus.word_valid = word_valid_q;

endmodule

// File: tb/tb_fifo_nibble_packer.sv
// Bench for fifo_nibble_packer: a latency-1 FIFO model feeds the packer, scenario
// tasks check directed cases and a randomized run against packed-word expectations.
module tb_fifo_nibble_packer;
    import fifo_nibble_packer_pkg::*;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned NIBS  = 4;
    localparam int unsigned CNT_W = cnt_width(NIBS);

    logic rclk  = 1'b0;
    logic rst_n = 1'b0;
    logic stall = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    // FIFO model: array with independent write (bench) and read (clocked) pointers.
    logic [3:0] fmem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always #5 rclk = ~rclk;

    fifo_nibble_packer_if #(.NIB_W(NIB_W), .NIBS(NIBS)) bus ();

    fifo_nibble_packer #(.NIB_W(NIB_W), .NIBS(NIBS)) dut (
        .rclk  (rclk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.mem_empty = stall || (wr_ptr == rd_ptr);

    always @(posedge rclk) begin
        if (bus.r_en) begin
            bus.fifo_data <= fmem[rd_ptr % 1024];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    task automatic push(input logic [3:0] v);
        fmem[wr_ptr % 1024] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        push(4'h5);
        #1;
        n_cmp++; if (bus.r_en !== 1'b0) begin
            n_bad++; $display("FAIL reset_r_en got %b want 0", bus.r_en);
        end
        n_cmp++; if (bus.word_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid got %b want 0", bus.word_valid);
        end
        n_cmp++; if (bus.word_out !== 16'h0000) begin
            n_bad++; $display("FAIL reset_word got %h want 0000", bus.word_out);
        end
        n_cmp++; if (bus.word_cnt !== 3'd0) begin
            n_bad++; $display("FAIL reset_cnt got %0d want 0", bus.word_cnt);
        end
        @(negedge rclk);
        wr_ptr = rd_ptr;
        @(negedge rclk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_word;
        int ren_cnt = 0;
        int first_valid = -1;
        int valid_cyc = 0;
        logic [15:0] got_w = '0;
        logic [CNT_W-1:0] got_c = '0;
        @(negedge rclk);
        bus.word_ready = 1'b1;
        push(4'h3); push(4'h9); push(4'h7); push(4'hF);
        #1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) begin @(negedge rclk); #1; end
            if (bus.r_en) ren_cnt++;
            if (bus.word_valid) begin
                valid_cyc++;
                if (first_valid < 0) begin
                    first_valid = c; got_w = bus.word_out; got_c = bus.word_cnt;
                end
            end
        end
        n_cmp++; if (ren_cnt != 4) begin
            n_bad++; $display("FAIL full_ren_cycles got %0d want 4", ren_cnt);
        end
        n_cmp++; if (first_valid != 5) begin
            n_bad++; $display("FAIL full_valid_cycle got %0d want 5", first_valid);
        end
        n_cmp++; if (valid_cyc != 1) begin
            n_bad++; $display("FAIL full_valid_len got %0d want 1", valid_cyc);
        end
        n_cmp++; if (got_w !== 16'hF793) begin
            n_bad++; $display("FAIL full_word got %h want f793", got_w);
        end
        n_cmp++; if (got_c !== 3'd4) begin
            n_bad++; $display("FAIL full_cnt got %0d want 4", got_c);
        end
    endtask

    task automatic test_backpressure;
        logic [3:0] nib [8];
        logic [15:0] exp1, exp2;
        int guard;
        @(negedge rclk);
        bus.word_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            nib[i] = 4'($urandom);
            push(nib[i]);
        end
        exp1 = {nib[3], nib[2], nib[1], nib[0]};
        exp2 = {nib[7], nib[6], nib[5], nib[4]};
        #1;
        guard = 0;
        while (!bus.word_valid && guard < 20) begin @(negedge rclk); #1; guard++; end
        n_cmp++; if (guard >= 20) begin
            n_bad++; $display("FAIL bp_first_timeout got no valid want valid");
        end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge rclk); #1; end
            n_cmp++;
            if (bus.word_valid !== 1'b1 || bus.word_out !== exp1 || bus.r_en !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cyc %0d got v=%b w=%h r_en=%b want v=1 w=%h r_en=0",
                         k, bus.word_valid, bus.word_out, bus.r_en, exp1);
            end
        end
        @(negedge rclk);
        bus.word_ready = 1'b1;
        @(negedge rclk); #1;
        n_cmp++;
        if (bus.word_valid !== 1'b0 || bus.r_en !== 1'b1 || bus.word_out !== 16'h0 ||
            bus.word_cnt !== 3'd0) begin
            n_bad++;
            $display("FAIL bp_release got v=%b r_en=%b w=%h c=%0d want v=0 r_en=1 w=0 c=0",
                     bus.word_valid, bus.r_en, bus.word_out, bus.word_cnt);
        end
        guard = 0;
        while (!bus.word_valid && guard < 20) begin @(negedge rclk); #1; guard++; end
        n_cmp++; if (bus.word_out !== exp2 || guard >= 20) begin
            n_bad++; $display("FAIL bp_second_word got %h want %h", bus.word_out, exp2);
        end
    endtask

    task automatic test_empty_stall;
        logic [3:0] vals [4];
        int guard;
        vals[0] = 4'hA; vals[1] = 4'hB; vals[2] = 4'hC; vals[3] = 4'hD;
        bus.word_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge rclk);
            push(vals[k]);
            #1;
            n_cmp++; if (bus.r_en !== 1'b1) begin
                n_bad++; $display("FAIL stall_pop %0d got r_en=%b want 1", k, bus.r_en);
            end
            for (int e = 0; e < 2; e++) begin
                @(negedge rclk); #1;
                n_cmp++; if (bus.r_en !== 1'b0 || bus.mem_empty !== 1'b1) begin
                    n_bad++; $display("FAIL stall_idle %0d got r_en=%b empty=%b want 0 1",
                                      k, bus.r_en, bus.mem_empty);
                end
            end
        end
        guard = 0;
        while (!bus.word_valid && guard < 20) begin @(negedge rclk); #1; guard++; end
        n_cmp++; if (bus.word_out !== 16'hDCBA || bus.word_cnt !== 3'd4 || guard >= 20) begin
            n_bad++; $display("FAIL stall_word got %h/%0d want dcba/4", bus.word_out,
                              bus.word_cnt);
        end
    endtask

    task automatic test_flush;
        int guard;
        bit seen;
        bus.word_ready = 1'b1;
        @(negedge rclk);
        push(4'h5); push(4'h6); push(4'h2);
        repeat (3) @(negedge rclk);
        bus.flush = 1'b1;
        #1;
        n_cmp++; if (bus.r_en !== 1'b0) begin
            n_bad++; $display("FAIL flush_cycle_r_en got %b want 0", bus.r_en);
        end
        @(negedge rclk);
        bus.flush = 1'b0;
        push(4'hE);
        #1;
        n_cmp++; if (bus.r_en !== 1'b0) begin
            n_bad++; $display("FAIL flush_pend_r_en got %b want 0", bus.r_en);
        end
        guard = 0;
        while (!bus.word_valid && guard < 20) begin @(negedge rclk); #1; guard++; end
        n_cmp++; if (bus.word_out !== 16'h0265 || bus.word_cnt !== 3'd3 || guard >= 20) begin
            n_bad++; $display("FAIL flush_partial got %h/%0d want 0265/3", bus.word_out,
                              bus.word_cnt);
        end
        repeat (4) @(negedge rclk);
        bus.flush = 1'b1;
        @(negedge rclk);
        bus.flush = 1'b0;
        #1;
        guard = 0;
        while (!bus.word_valid && guard < 20) begin @(negedge rclk); #1; guard++; end
        n_cmp++; if (bus.word_out !== 16'h000E || bus.word_cnt !== 3'd1 || guard >= 20) begin
            n_bad++; $display("FAIL flush_single got %h/%0d want 000e/1", bus.word_out,
                              bus.word_cnt);
        end
        repeat (3) @(negedge rclk);
        bus.flush = 1'b1;
        @(negedge rclk);
        bus.flush = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge rclk); #1;
            if (bus.word_valid) seen = 1'b1;
        end
        n_cmp++; if (seen) begin
            n_bad++; $display("FAIL flush_empty got valid=1 want no word");
        end
    endtask

    task automatic test_mid_reset;
        int guard;
        bus.word_ready = 1'b1;
        @(negedge rclk);
        push(4'h1); push(4'h2); push(4'h3); push(4'h4);
        repeat (3) @(negedge rclk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.r_en !== 1'b0 || bus.word_valid !== 1'b0 || bus.word_out !== 16'h0 ||
            bus.word_cnt !== 3'd0) begin
            n_bad++; $display("FAIL midrst_clear got r_en=%b v=%b w=%h c=%0d want all 0",
                              bus.r_en, bus.word_valid, bus.word_out, bus.word_cnt);
        end
        @(negedge rclk);
        wr_ptr = rd_ptr;
        @(negedge rclk);
        rst_n = 1'b1;
        push(4'h8); push(4'h9); push(4'hA); push(4'hB);
        #1;
        guard = 0;
        while (!bus.word_valid && guard < 20) begin @(negedge rclk); #1; guard++; end
        n_cmp++; if (bus.word_out !== 16'hBA98 || bus.word_cnt !== 3'd4 || guard >= 20) begin
            n_bad++; $display("FAIL midrst_word got %h/%0d want ba98/4", bus.word_out,
                              bus.word_cnt);
        end
    endtask

    task automatic test_random;
        localparam int NWords = 25;
        logic [15:0] exp_q [$];
        logic [15:0] cur;
        logic [15:0] e;
        logic [3:0] v;
        int pushed = 0;
        int got = 0;
        int cyc = 0;
        cur = '0;
        while (got < NWords && cyc < 3000) begin
            @(negedge rclk);
            cyc++;
            stall = ($urandom_range(0, 3) == 0);
            bus.word_ready = ($urandom_range(0, 2) != 0);
            if (pushed < NWords * 4 && $urandom_range(0, 1) == 1) begin
                v = 4'($urandom);
                push(v);
                cur[4*(pushed%4) +: 4] = v;
                pushed++;
                if (pushed % 4 == 0) exp_q.push_back(cur);
            end
            #1;
            n_cmp++; if (bus.r_en && bus.mem_empty) begin
                n_bad++; $display("FAIL rnd_pop_empty cyc %0d got r_en=1 want 0", cyc);
            end
            n_cmp++; if (bus.r_en && bus.word_valid) begin
                n_bad++; $display("FAIL rnd_pop_hold cyc %0d got r_en=1 want 0", cyc);
            end
            if (bus.word_valid && bus.word_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++; $display("FAIL rnd_extra got %h want no word", bus.word_out);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.word_out !== e || bus.word_cnt !== 3'd4) begin
                        n_bad++; $display("FAIL rnd_word %0d got %h/%0d want %h/4", got,
                                          bus.word_out, bus.word_cnt, e);
                    end
                end
                got++;
            end
        end
        stall = 1'b0;
        n_cmp++; if (got != NWords) begin
            n_bad++; $display("FAIL rnd_count got %0d want %0d", got, NWords);
        end
    endtask

    initial begin
        bus.flush      = 1'b0;
        bus.word_ready = 1'b0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_empty_stall();
        test_flush();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
